// File: rtl/wb_gpio_bank_pkg.sv
// Shared constants and helpers for the Wishbone GPIO bank.
// Register indices are the word offsets decoded from wb_adr_i[4:2].
package wb_gpio_bank_pkg;

  localparam int GPIO_ADDR_BITS = 5;

  localparam logic [2:0] REG_IN      = 3'd0;
  localparam logic [2:0] REG_OUT     = 3'd1;
  localparam logic [2:0] REG_DIR     = 3'd2;
  localparam logic [2:0] REG_SET     = 3'd3;
  localparam logic [2:0] REG_CLR     = 3'd4;
  localparam logic [2:0] REG_RISE_EN = 3'd5;
  localparam logic [2:0] REG_FALL_EN = 3'd6;
  localparam logic [2:0] REG_STATUS  = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_gpio_bank_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous pad inputs.
// Each bit is synchronised independently; no bus coherency implied.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/wb_gpio_bank.sv
// Wishbone-classic GPIO bank: OUT/DIR registers, set/clear aliases,
// synchronised inputs and W1C edge-interrupt status with a level irq.
module wb_gpio_bank
  import wb_gpio_bank_pkg::*;
#(
  parameter int                    GPIO_WIDTH  = 32,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [GPIO_WIDTH-1:0] DIR_RESET   = '0,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam int W = GPIO_WIDTH;

  logic [0:0]   state_q, state_d;
  logic [31:0]  dat_q, dat_d;
  logic [W-1:0] in_w;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] dir_q, dir_d;
  logic [W-1:0] rise_en_q, rise_en_d;
  logic [W-1:0] fall_en_q, fall_en_d;
  logic [W-1:0] status_q, status_d;

  logic         req;
  logic         wr;
  logic [2:0]   idx;
  logic [W-1:0] wd;
  logic [W-1:0] wm;
  logic [W-1:0] evt;
  logic [31:0]  rd;
  logic         unused_adr;

  gpio_sync #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .din   (gpio_i),
    .dout  (in_w)
  );

  assign req        = wb_cyc_i & wb_stb_i & (state_q == ST_IDLE);
  assign wr         = req & wb_we_i;
  assign idx        = wb_adr_i[4:2];
  assign wd         = W'(wb_dat_i);
  assign wm         = W'(sel_mask(wb_sel_i));
  assign unused_adr = ^wb_adr_i[1:0];

  // Edges come from the synchronised copy only, never from the pads.
  assign evt = (in_w & ~prev_q & rise_en_q)
             | (~in_w & prev_q & fall_en_q);

  always_comb begin
    state_d   = req ? ST_ACK : ST_IDLE;
    prev_d    = in_w;
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    if (wr) begin
      case (idx)
        REG_OUT:     out_d     = (out_q & ~wm) | (wd & wm);
        REG_DIR:     dir_d     = (dir_q & ~wm) | (wd & wm);
        REG_SET:     out_d     = out_q | (wd & wm);
        REG_CLR:     out_d     = out_q & ~(wd & wm);
        REG_RISE_EN: rise_en_d = (rise_en_q & ~wm) | (wd & wm);
        REG_FALL_EN: fall_en_d = (fall_en_q & ~wm) | (wd & wm);
        REG_STATUS:  status_d  = status_q & ~(wd & wm);
        default:     ;
      endcase
    end
    // A new event beats a same-cycle clear.
    status_d = status_d | evt;
  end

  always_comb begin
    rd = '0;
    case (idx)
      REG_IN:      rd = 32'(in_w);
      REG_OUT:     rd = 32'(out_q);
      REG_DIR:     rd = 32'(dir_q);
      REG_RISE_EN: rd = 32'(rise_en_q);
      REG_FALL_EN: rd = 32'(fall_en_q);
      REG_STATUS:  rd = 32'(status_q);
      default:     rd = '0;
    endcase
    dat_d = req ? rd : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dat_q     <= '0;
      prev_q    <= '0;
      out_q     <= OUT_RESET;
      dir_q     <= DIR_RESET;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      dat_q     <= dat_d;
      prev_q    <= prev_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
    end
  end

  assign wb_ack_o = (state_q == ST_ACK);
  assign wb_dat_o = dat_q;
  assign gpio_o   = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |status_q;

endmodule
